// File: rtl/rr_slot_arbiter.sv
// Round-robin slot arbiter: one grant at a time, bounded tenure,
// rotating priority and a single dead cycle between grants.
module rr_slot_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int PTR_W    = $clog2(N_REQ),
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [PTR_W-1:0] gnt_id,
    output logic [CNT_W-1:0] hold_cnt,
    output logic             expired
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;

    logic             win_found;
    logic [PTR_W-1:0] win_id;
    logic [PTR_W-1:0] nxt_ptr;
    int               idx;

    // Circular search of req starting at the priority pointer
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = PTR_W'(idx);
            end
        end
    end

    assign nxt_ptr = (id_q == PTR_W'(N_REQ - 1)) ? '0 : id_q + PTR_W'(1);

    // Next-state and next-output logic of the grant FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        exp_d   = 1'b0;
        unique case (state_q)
            IDLE, RELEASE: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << win_id;
                    id_d    = win_id;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (!req[id_q]) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = nxt_ptr;
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = nxt_ptr;
                    exp_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; all hold while en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            exp_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign gnt_id    = id_q;
    assign hold_cnt  = cnt_q;
    assign expired   = exp_q & en;

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Scoreboard bench for rr_slot_arbiter (N_REQ=4, MAX_HOLD=8):
// directed vectors queue expected outputs; a monitor pops and compares.
module tb_rr_slot_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic [3:0] hold_cnt;
    logic       expired;

    typedef struct packed {
        logic [3:0] gnt;
        logic       gv;
        logic [1:0] id;
        logic [3:0] cnt;
        logic       ex;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    rr_slot_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .req(req),
        .gnt(gnt),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id),
        .hold_cnt(hold_cnt),
        .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic exp_t G(input int id, input int h);
        exp_t x;
        logic [3:0] one;
        one   = 4'b0001;
        x.gnt = one << id;
        x.gv  = 1'b1;
        x.id  = 2'(id);
        x.cnt = 4'(h);
        x.ex  = 1'b0;
        return x;
    endfunction

    function automatic exp_t R(input int id, input logic ex);
        exp_t x;
        x.gnt = 4'b0000;
        x.gv  = 1'b0;
        x.id  = 2'(id);
        x.cnt = 4'd0;
        x.ex  = ex;
        return x;
    endfunction

    function automatic exp_t act();
        exp_t x;
        x.gnt = gnt;
        x.gv  = gnt_valid;
        x.id  = gnt_id;
        x.cnt = hold_cnt;
        x.ex  = expired;
        return x;
    endfunction

    task automatic chk(input string name, input exp_t a, input exp_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b v=%b id=%0d cnt=%0d exp=%b, want gnt=%b v=%b id=%0d cnt=%0d exp=%b",
                     name, a.gnt, a.gv, a.id, a.cnt, a.ex,
                     e.gnt, e.gv, e.id, e.cnt, e.ex);
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic e, input exp_t x);
        @(negedge clk);
        req = r;
        en  = e;
        q.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d pending, want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: compare DUT outputs just after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("vec", act(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        req   = 4'b0000;
        #12;
        chk("reset", act(), R(0, 1'b0));
        @(negedge clk);
        reset = 1'b0;

        // Idle while req=0
        for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, R(0, 1'b0));

        // Single requester 2, dropped after four grant cycles
        for (int h = 0; h < 4; h++) cyc(4'b0100, 1'b1, G(2, h));
        cyc(4'b0000, 1'b1, R(2, 1'b0));
        cyc(4'b0000, 1'b1, R(2, 1'b0));

        // Wrap: ptr=3, req=1001 -> id 3 until expiry, then id 0
        for (int h = 0; h < 8; h++) cyc(4'b1001, 1'b1, G(3, h));
        cyc(4'b1001, 1'b1, R(3, 1'b1));
        cyc(4'b1001, 1'b1, G(0, 0));
        cyc(4'b0000, 1'b1, R(0, 1'b0));
        cyc(4'b0000, 1'b1, R(0, 1'b0));

        // Lone requester 1 expires, gap, re-granted
        for (int h = 0; h < 8; h++) cyc(4'b0010, 1'b1, G(1, h));
        cyc(4'b0010, 1'b1, R(1, 1'b1));
        for (int h = 0; h < 3; h++) cyc(4'b0010, 1'b1, G(1, h));
        drain();

        // Async reset mid-grant drops gnt before the next edge
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", act(), R(0, 1'b0));
        @(negedge clk);
        req   = 4'b0000;
        reset = 1'b0;

        // All requesting: 0,1,2,3,0 with 8-cycle tenures and expiry pulses
        for (int g = 0; g < 5; g++) begin
            for (int h = 0; h < 8; h++) cyc(4'b1111, 1'b1, G(g % 4, h));
            cyc(4'b1111, 1'b1, R(g % 4, 1'b1));
        end
        cyc(4'b0000, 1'b1, R(0, 1'b0));

        // Enable low for 5 cycles at hold_cnt=3 delays expiry by 5
        for (int h = 0; h < 4; h++) cyc(4'b0100, 1'b1, G(2, h));
        for (int i = 0; i < 5; i++) cyc(4'b0100, 1'b0, G(2, 3));
        for (int h = 4; h < 8; h++) cyc(4'b0100, 1'b1, G(2, h));
        cyc(4'b0100, 1'b1, R(2, 1'b1));
        cyc(4'b0000, 1'b1, R(2, 1'b0));
        cyc(4'b0000, 1'b1, R(2, 1'b0));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
